// File: rtl/elink_pkg.sv
// elink_pkg: shared constants for the elink TX arbitration slice.
// Holds the default packet width, channel indices and FSM state encoding,
// plus a ring-successor helper used by the arbiter pointer logic.
package elink_pkg;

  localparam int PW_DEF = 104;

  // Channel indices; CH_NONE marks an empty output register / no owner.
  localparam logic [1:0] CH_WR   = 2'd0;
  localparam logic [1:0] CH_RD   = 2'd1;
  localparam logic [1:0] CH_RR   = 2'd2;
  localparam logic [1:0] CH_NONE = 2'd3;

  // Arbiter FSM encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Next channel in ring order wr -> rd -> rr -> wr.
  function automatic logic [1:0] ch_next(input logic [1:0] ch);
    logic [1:0] nxt;
    case (ch)
      CH_WR:   nxt = CH_RD;
      CH_RD:   nxt = CH_RR;
      default: nxt = CH_WR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/elink_rr_pick3.sv
// elink_rr_pick3: 3-way ring priority picker, one-hot grant.
// Latency: purely combinational.
// Backpressure: none; gnt is zero when no request is present.
// Ports: req[2:0] requests (bit = channel), ptr[1:0] first channel to look at
//        (3 is treated as wr), gnt[2:0] one-hot winner.
module elink_rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd1: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/elink_tx_arbiter.sv
// elink_tx_arbiter: shares the elink TX packet port between txwr, txrd, txrr.
// Latency: accepted packet is on out_* the next cycle; 1 packet/cycle sustained.
// Backpressure: out_wait freezes the output register and raises every *_wait.
// Ports: clock/reset (async active-low); per channel X in {wr,rd,rr}:
//        X_access/X_packet in, X_wait out; out_access/out_packet registered
//        to the serializer, out_wait from it; grant_id owner of out register.
module elink_tx_arbiter
  import elink_pkg::*;
#(
  parameter int PW        = PW_DEF,
  parameter int MAX_BURST = 8,
  parameter int RR_PRIO   = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_access,
  input  logic [PW-1:0] wr_packet,
  output logic          wr_wait,
  input  logic          rd_access,
  input  logic [PW-1:0] rd_packet,
  output logic          rd_wait,
  input  logic          rr_access,
  input  logic [PW-1:0] rr_packet,
  output logic          rr_wait,
  output logic          out_access,
  output logic [PW-1:0] out_packet,
  input  logic          out_wait,
  output logic [1:0]    grant_id
);

  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  logic [0:0]    state;
  logic [1:0]    owner;
  logic [1:0]    ptr;
  logic [7:0]    burst_cnt;

  logic          load;
  logic [3:0]    req4;
  logic          owner_req;
  logic          others_req;
  logic          keep;
  logic [1:0]    pick_ptr;
  logic [2:0]    gnt;
  logic [1:0]    pick_id;
  logic [1:0]    grant_nxt;
  logic [PW-1:0] sel_pkt;

  // Output register can take a new packet this cycle.
  assign load = ~out_access | ~out_wait;

  // Padded so owner==CH_NONE indexes a constant zero.
  assign req4       = {1'b0, rr_access, rd_access, wr_access};
  assign owner_req  = (state == ST_HOLD) & req4[owner];
  assign others_req = |(req4[2:0] & ~(3'b001 << owner));
  assign keep       = owner_req & ((burst_cnt < MAXB) | ~others_req);

  // Leaving an owner re-arbitrates from its successor in the same cycle.
  assign pick_ptr = (state == ST_HOLD) ? ch_next(owner) : ptr;

  elink_rr_pick3 u_pick (
    .req (req4[2:0]),
    .ptr (pick_ptr),
    .gnt (gnt)
  );

  always_comb begin
    pick_id = CH_NONE;
    if      (gnt[0]) pick_id = CH_WR;
    else if (gnt[1]) pick_id = CH_RD;
    else if (gnt[2]) pick_id = CH_RR;
  end

  // With RR_PRIO the read-response channel beats everything, including an
  // ongoing wr/rd burst, and its own burst is never cut by the counter.
  always_comb begin
    grant_nxt = pick_id;
    if ((RR_PRIO != 0) && rr_access) grant_nxt = CH_RR;
    else if (keep)                   grant_nxt = owner;
  end

  always_comb begin
    sel_pkt = '0;
    case (grant_nxt)
      CH_WR:   sel_pkt = wr_packet;
      CH_RD:   sel_pkt = rd_packet;
      CH_RR:   sel_pkt = rr_packet;
      default: sel_pkt = '0;
    endcase
  end

  // Waits are held high through reset so no producer sees a transfer.
  assign wr_wait = ~reset | ~load | (grant_nxt != CH_WR);
  assign rd_wait = ~reset | ~load | (grant_nxt != CH_RD);
  assign rr_wait = ~reset | ~load | (grant_nxt != CH_RR);

  // All arbitration state moves only on load cycles, so a stall never ages
  // a burst or shifts the pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_access <= 1'b0;
      out_packet <= '0;
      grant_id   <= CH_NONE;
      burst_cnt  <= 8'd0;
      ptr        <= CH_WR;
      owner      <= CH_NONE;
      state      <= ST_IDLE;
    end else if (load) begin
      if (grant_nxt != CH_NONE) begin
        out_access <= 1'b1;
        out_packet <= sel_pkt;
        grant_id   <= grant_nxt;
        if ((state == ST_HOLD) && (grant_nxt == owner)) begin
          if (burst_cnt < MAXB) burst_cnt <= burst_cnt + 8'd1;
        end else begin
          if (state == ST_HOLD) ptr <= ch_next(owner);
          owner     <= grant_nxt;
          state     <= ST_HOLD;
          burst_cnt <= 8'd1;
        end
      end else begin
        out_access <= 1'b0;
        grant_id   <= CH_NONE;
        if (state == ST_HOLD) ptr <= ch_next(owner);
        owner      <= CH_NONE;
        state      <= ST_IDLE;
        burst_cnt  <= 8'd0;
      end
    end
  end

endmodule
